bus_memory_responder: RTL and testbench
=======================================

// Module: bus_memory_responder
// PURPOSE
//  Bus responder (slave) for the same burst bus the DMA custom instruction uses as initiator.
//  Holds a word-addressed on-chip memory window at BASE_ADDRESS.
//  Accepts single/burst writes from an initiator.
//  Answers single/burst reads with streamed dataValid words, then endTransaction.
//  Signals busError for misaligned or out-of-window bursts.
// PARAMETERS
//  BASE_ADDRESS  32'h5000_0000  byte address of word 0; aligned to window size
//  ADDR_WIDTH    9              log2(number of 32-bit words); window = 4*2^ADDR_WIDTH bytes
// PORTS
//  clock               in   1   single clock, rising edge
//  reset               in   1   asynchronous, active-low reset
//  beginTransactionIn  in   1   1-cycle start strobe; address on addressDataIn
//  endTransactionIn    in   1   initiator ends write burst / aborts read
//  readNotWriteIn      in   1   sampled with beginTransactionIn; 1=read
//  byteEnablesIn       in   4   sampled with beginTransactionIn; write lane mask
//  burstSizeIn         in   8   sampled with beginTransactionIn; words-1
//  addressDataIn       in   32  address (begin cycle) / write data (dataValidIn cycles)
//  dataValidIn         in   1   write data word present
//  addressDataOut      out  32  read data; 0 when dataValidOut=0
//  dataValidOut        out  1   read data word present
//  endTransactionOut   out  1   1-cycle strobe after last read word
//  busErrorOut         out  1   1-cycle error strobe
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; internal counters 0; memory contents not cleared.
//  Reset mid-burst: same, immediately. No endTransactionOut or busErrorOut is emitted for the aborted transfer.
//  Select: addressDataIn[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2] at beginTransactionIn in IDLE.
//    Not selected -> stay IDLE, drive nothing.
//  beginTransactionIn outside IDLE is ignored.
//  Word index w = addressDataIn[ADDR_WIDTH+1:2]. Error if addr[1:0]!=0 or w+burstSizeIn > 2^ADDR_WIDTH-1.
//  Error check uses ADDR_WIDTH+1 bit sum, no wrap-around.
//  States: IDLE, ERROR, READ_FETCH, READ_BURST, READ_END, WRITE.
//  IDLE -> ERROR (selected & error), READ_FETCH (selected & read), WRITE (selected & write).
//  ERROR: busErrorOut=1 for exactly one cycle (begin T -> busErrorOut T+1); -> IDLE.
//    No memory access.
//  READ_FETCH: issue sync read of word w (1-cycle RAM latency); -> READ_BURST.
//  READ_BURST: one word per cycle, no gaps.
//    First dataValidOut at T+2, last at T+2+burstSizeIn.
//    Address increments by 1 word; next read issued each cycle.
//    After last word -> READ_END.
//  READ_END: endTransactionOut=1 one cycle (T+3+burstSizeIn); -> IDLE.
//  Read abort: endTransactionIn=1 in READ_FETCH/READ_BURST -> IDLE next cycle.
//    dataValidOut=0 from that edge; no endTransactionOut.
//  WRITE: each dataValidIn cycle writes addressDataIn to current word, lanes per byteEnables, then word+1.
//    Words beyond burstSizeIn+1 are dropped (no memory write).
//    endTransactionIn=1 -> IDLE; if dataValidIn same cycle, that word is written first.
//    byteEnables 0000 -> no memory change.
//  Byte lane mapping: byteEnables[i] covers data[8i+7:8i]. Read ignores byteEnables.
//  Outputs registered; addressDataOut forced 0 whenever dataValidOut=0.
//  Burst counter 9 bits: burstSizeIn=255 -> 256 words.
// TESTING
//  1. Write burst BASE, burst=3, data A0..A3, be=1111.
//     Then read BASE, burst=3, begin at T -> dataValidOut T+2..T+5 = A0..A3; endTransactionOut T+6 only.
//  2. Mem[5]=0x11223344; write BASE+0x14, be=0011, data 0xDEADBEEF; read back -> 0x1122BEEF.
//  3. begin at BASE+0x1000 (outside window), read and write -> no output activity, memory unchanged.
//  4. begin BASE+0x7FC, burst=1 -> busErrorOut=1 at T+1 only, no dataValidOut.
//     Also BASE+0x2 -> same.
//  5. Read burst=7, endTransactionIn at 3rd valid word -> dataValidOut low next cycle, no endTransactionOut.
//     Next read of burst=0 works normally.
//  6. reset low during write burst after 2 of 4 words -> outputs 0.
//     Words 0-1 written, 2-3 unchanged; normal read afterwards.

Source files
------------

// File: rtl/bus_memory_responder.sv
// Burst-bus responder backed by a word-addressed on-chip memory window.
// Streams read bursts one word per cycle and flags misaligned or out-of-window bursts.
module bus_memory_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int unsigned ADDR_WIDTH   = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic        endTransactionIn,
  input  logic        readNotWriteIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busErrorOut
);

  localparam int unsigned Words = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StError,
    StReadFetch,
    StReadBurst,
    StReadEnd,
    StWrite
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [8:0]            count_q;
  logic [3:0]            be_q;
  logic                  bus_error_q;
  logic                  end_out_q;
  logic                  valid_q;
  logic [31:0]           rdata_q;

  logic [31:0]           mem [Words];

  logic [ADDR_WIDTH-1:0] begin_word;
  logic [31:0]           last_word;
  logic                  selected;
  logic                  addr_error;
  logic                  rd_en;
  logic                  wr_en;

  always_comb begin
    begin_word = addressDataIn[ADDR_WIDTH+1:2];
    selected   = beginTransactionIn &&
                 (addressDataIn[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]);
    // Wide sum so a burst running past the top of the window cannot wrap to look legal.
    last_word  = 32'(begin_word) + 32'(burstSizeIn);
    addr_error = (addressDataIn[1:0] != 2'b00) || (last_word > Words - 1);
    rd_en      = ((state_q == StReadFetch) || (state_q == StReadBurst)) && !endTransactionIn;
    wr_en      = (state_q == StWrite) && dataValidIn && (count_q != 9'd0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      word_q      <= '0;
      count_q     <= '0;
      be_q        <= '0;
      bus_error_q <= 1'b0;
      end_out_q   <= 1'b0;
    end else begin
      bus_error_q <= 1'b0;
      end_out_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (selected) begin
            if (addr_error) begin
              bus_error_q <= 1'b1;
              state_q     <= StError;
            end else begin
              word_q  <= begin_word;
              count_q <= 9'(burstSizeIn) + 9'd1;
              be_q    <= byteEnablesIn;
              state_q <= readNotWriteIn ? StReadFetch : StWrite;
            end
          end
        end
        StError: state_q <= StIdle;
        StReadFetch, StReadBurst: begin
          if (endTransactionIn) begin
            count_q <= '0;
            state_q <= StIdle;
          end else begin
            word_q  <= word_q + ADDR_WIDTH'(1);
            count_q <= count_q - 9'd1;
            state_q <= (count_q == 9'd1) ? StReadEnd : StReadBurst;
          end
        end
        StReadEnd: begin
          end_out_q <= 1'b1;
          state_q   <= StIdle;
        end
        StWrite: begin
          if (wr_en) begin
            word_q  <= word_q + ADDR_WIDTH'(1);
            count_q <= count_q - 9'd1;
          end
          if (endTransactionIn) begin
            count_q <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read port register doubles as the output register; it is zeroed when no word is issued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      valid_q <= rd_en;
      rdata_q <= rd_en ? mem[word_q] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[word_q][8*i +: 8] <= addressDataIn[8*i +: 8];
      end
    end
  end

  assign addressDataOut    = rdata_q;
  assign dataValidOut      = valid_q;
  assign endTransactionOut = end_out_q;
  assign busErrorOut       = bus_error_q;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Scoreboarded bench for bus_memory_responder: read words are queued from a memory model
// when a read is issued and compared as dataValidOut words stream out.
module tb_bus_memory_responder;

  localparam logic [31:0] Base = 32'h5000_0000;
  localparam int unsigned Aw   = 9;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        beginTransactionIn = 1'b0;
  logic        endTransactionIn = 1'b0;
  logic        readNotWriteIn = 1'b0;
  logic [3:0]  byteEnablesIn = '0;
  logic [7:0]  burstSizeIn = '0;
  logic [31:0] addressDataIn = '0;
  logic        dataValidIn = 1'b0;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busErrorOut;

  bus_memory_responder #(
    .BASE_ADDRESS(Base),
    .ADDR_WIDTH  (Aw)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .beginTransactionIn(beginTransactionIn),
    .endTransactionIn  (endTransactionIn),
    .readNotWriteIn    (readNotWriteIn),
    .byteEnablesIn     (byteEnablesIn),
    .burstSizeIn       (burstSizeIn),
    .addressDataIn     (addressDataIn),
    .dataValidIn       (dataValidIn),
    .addressDataOut    (addressDataOut),
    .dataValidOut      (dataValidOut),
    .endTransactionOut (endTransactionOut),
    .busErrorOut       (busErrorOut)
  );

  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  logic [31:0] exp_q [$];
  int          valid_cycles [$];
  int          end_cycles [$];
  int          err_cycles [$];
  logic [31:0] model [512];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      if (dataValidOut) begin
        valid_cycles.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_valid", 32'(dataValidOut), 32'd0);
        else check("rd_data", addressDataOut, exp_q.pop_front());
      end else begin
        check("data_zero_when_invalid", addressDataOut, 32'd0);
      end
      if (endTransactionOut) end_cycles.push_back(cyc);
      if (busErrorOut) err_cycles.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    valid_cycles.delete();
    end_cycles.delete();
    err_cycles.delete();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input int n,
                          input logic [31:0] d0, input bit upd);
    int          w;
    logic [31:0] d;
    w                  = int'((addr - Base) >> 2);
    beginTransactionIn = 1'b1;
    readNotWriteIn     = 1'b0;
    byteEnablesIn      = be;
    burstSizeIn        = 8'(n - 1);
    addressDataIn      = addr;
    step();
    beginTransactionIn = 1'b0;
    for (int i = 0; i < n; i++) begin
      d                = d0 + 32'(i) * 32'h0101_0101;
      dataValidIn      = 1'b1;
      addressDataIn    = d;
      endTransactionIn = (i == n - 1);
      if (upd) model[w+i] = merge(model[w+i], d, be);
      step();
    end
    dataValidIn      = 1'b0;
    endTransactionIn = 1'b0;
    addressDataIn    = '0;
    step();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] burst, input int n_push,
                         output int t);
    int w;
    w = int'((addr - Base) >> 2);
    for (int i = 0; i < n_push; i++) exp_q.push_back(model[w+i]);
    beginTransactionIn = 1'b1;
    readNotWriteIn     = 1'b1;
    byteEnablesIn      = '0;
    burstSizeIn        = burst;
    addressDataIn      = addr;
    t                  = cyc;
    step();
    beginTransactionIn = 1'b0;
    readNotWriteIn     = 1'b0;
    addressDataIn      = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;

    steps(2);
    check("rst_valid", 32'(dataValidOut), 32'd0);
    check("rst_data", addressDataOut, 32'd0);
    check("rst_end", 32'(endTransactionOut), 32'd0);
    check("rst_err", 32'(busErrorOut), 32'd0);
    reset = 1'b1;
    steps(2);

    // Write burst then read it back with exact timing.
    do_write(Base, 4'hF, 4, 32'hA0A0_A0A0, 1'b1);
    clr();
    do_read(Base, 8'd3, 4, t);
    steps(8);
    check("t1_nvalid", valid_cycles.size(), 32'd4);
    check("t1_first", at(valid_cycles, 0), t + 2);
    check("t1_last", at(valid_cycles, 3), t + 5);
    check("t1_nend", end_cycles.size(), 32'd1);
    check("t1_end", at(end_cycles, 0), t + 6);
    check("t1_nerr", err_cycles.size(), 32'd0);

    // Partial byte-lane write.
    do_write(Base + 32'h14, 4'hF, 1, 32'h1122_3344, 1'b1);
    do_write(Base + 32'h14, 4'b0011, 1, 32'hDEAD_BEEF, 1'b1);
    clr();
    do_read(Base + 32'h14, 8'd0, 1, t);
    steps(6);
    check("t2_nvalid", valid_cycles.size(), 32'd1);
    check("t2_end", at(end_cycles, 0), t + 3);

    // Outside the window: no activity, aliased word 0 untouched.
    clr();
    do_read(Base + 32'h1000, 8'd3, 0, t);
    steps(8);
    do_write(Base + 32'h1000, 4'hF, 2, 32'h5555_5555, 1'b0);
    steps(4);
    check("t3_nvalid", valid_cycles.size(), 32'd0);
    check("t3_nend", end_cycles.size(), 32'd0);
    check("t3_nerr", err_cycles.size(), 32'd0);
    do_read(Base, 8'd1, 2, t);
    steps(6);
    check("t3_readback_n", valid_cycles.size(), 32'd2);

    // Burst past the top of the window, then misaligned address.
    clr();
    do_read(Base + 32'h7FC, 8'd1, 0, t);
    steps(5);
    check("t4_nerr", err_cycles.size(), 32'd1);
    check("t4_err", at(err_cycles, 0), t + 1);
    check("t4_nvalid", valid_cycles.size(), 32'd0);
    check("t4_nend", end_cycles.size(), 32'd0);
    clr();
    do_read(Base + 32'h2, 8'd1, 0, t);
    steps(5);
    check("t4b_nerr", err_cycles.size(), 32'd1);
    check("t4b_err", at(err_cycles, 0), t + 1);
    check("t4b_nvalid", valid_cycles.size(), 32'd0);
    // Last word of the window with burst 0 is legal.
    do_write(Base + 32'h7FC, 4'hF, 1, 32'hC0FF_EE00, 1'b1);
    clr();
    do_read(Base + 32'h7FC, 8'd0, 1, t);
    steps(5);
    check("t4c_nerr", err_cycles.size(), 32'd0);
    check("t4c_nvalid", valid_cycles.size(), 32'd1);

    // Read abort at the third word, then a normal single read.
    do_write(Base + 32'h40, 4'hF, 8, 32'h7000_0010, 1'b1);
    clr();
    do_read(Base + 32'h40, 8'd7, 3, t);
    steps(3);
    endTransactionIn = 1'b1;
    step();
    endTransactionIn = 1'b0;
    steps(6);
    check("t5_nvalid", valid_cycles.size(), 32'd3);
    check("t5_last", at(valid_cycles, 2), t + 4);
    check("t5_nend", end_cycles.size(), 32'd0);
    clr();
    do_read(Base + 32'h40, 8'd0, 1, t);
    steps(5);
    check("t5b_first", at(valid_cycles, 0), t + 2);
    check("t5b_end", at(end_cycles, 0), t + 3);

    // Reset in the middle of a 4-word write burst.
    do_write(Base + 32'h80, 4'hF, 4, 32'hB0B0_B0B0, 1'b1);
    beginTransactionIn = 1'b1;
    readNotWriteIn     = 1'b0;
    byteEnablesIn      = 4'hF;
    burstSizeIn        = 8'd3;
    addressDataIn      = Base + 32'h80;
    step();
    beginTransactionIn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dataValidIn   = 1'b1;
      addressDataIn = 32'h6000_0000 + 32'(i);
      model[32+i]   = addressDataIn;
      step();
    end
    addressDataIn = 32'h6000_0002;
    reset         = 1'b0;
    #1;
    check("t6_rst_valid", 32'(dataValidOut), 32'd0);
    check("t6_rst_data", addressDataOut, 32'd0);
    check("t6_rst_end", 32'(endTransactionOut), 32'd0);
    check("t6_rst_err", 32'(busErrorOut), 32'd0);
    step();
    dataValidIn   = 1'b0;
    addressDataIn = '0;
    step();
    reset = 1'b1;
    step();
    clr();
    do_read(Base + 32'h80, 8'd3, 4, t);
    steps(8);
    check("t6_nvalid", valid_cycles.size(), 32'd4);
    check("t6_end", at(end_cycles, 0), t + 6);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
